// File: rtl/captura_clave.sv
// captura_clave: two-digit BCD keypad PIN capture with clear/enter keys and inactivity discard.
// Define CAPTURA_CLAVE_TIMEOUT_EN to build the inactivity timeout counter.
module captura_clave #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tecla_valida,
    input  logic [3:0] tecla_codigo,
    output logic [7:0] clave_ingresada,
    output logic       clave_lista,
    output logic [1:0] digitos_cuenta,
    output logic       error_entrada
);
    typedef enum logic [1:0] {
        ESPERA_D1    = 2'd0,
        ESPERA_D2    = 2'd1,
        ESPERA_ENTER = 2'd2
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [7:0] buffer_q, buffer_d;
    logic [7:0] clave_q, clave_d;
    logic       lista_q, lista_d;
    logic       error_q, error_d;
    logic       es_digito, es_borrar, es_enter, tecla_ok, expira;

    if (TIMEOUT_CICLOS < 2) begin : g_param_invalido
        $error("TIMEOUT_CICLOS must be at least 2");
    end

    assign es_digito = tecla_valida && tecla_codigo <= 4'd9;
    assign es_borrar = tecla_valida && tecla_codigo == 4'hA;
    assign es_enter  = tecla_valida && tecla_codigo == 4'hB;
    assign tecla_ok  = es_digito || es_borrar || es_enter;

`ifdef CAPTURA_CLAVE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CICLOS);
    logic [CW-1:0] cuenta_q, cuenta_d;
    // A key arriving on the expiry cycle wins, so expiry is only acted on when no valid key is present.
    assign expira   = estado_q != ESPERA_D1 && cuenta_q == CW'(TIMEOUT_CICLOS - 1);
    assign cuenta_d = (estado_q == ESPERA_D1 || tecla_ok || expira) ? '0 : cuenta_q + CW'(1);
    always_ff @(posedge clock) begin
        if (reset) cuenta_q <= '0;
        else       cuenta_q <= cuenta_d;
    end
`else
    assign expira = 1'b0;
`endif

    always_comb begin
        estado_d = estado_q;
        buffer_d = buffer_q;
        clave_d  = clave_q;
        lista_d  = 1'b0;
        error_d  = 1'b0;
        if (es_digito) begin
            if (estado_q == ESPERA_D1) begin
                buffer_d[7:4] = tecla_codigo;
                estado_d      = ESPERA_D2;
            end else if (estado_q == ESPERA_D2) begin
                buffer_d[3:0] = tecla_codigo;
                estado_d      = ESPERA_ENTER;
            end
        end else if (es_borrar) begin
            estado_d = ESPERA_D1;
        end else if (es_enter) begin
            estado_d = ESPERA_D1;
            lista_d  = estado_q == ESPERA_ENTER;
            error_d  = estado_q != ESPERA_ENTER;
            clave_d  = estado_q == ESPERA_ENTER ? buffer_q : clave_q;
        end else if (expira) begin
            estado_d = ESPERA_D1;
            error_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= ESPERA_D1;
            buffer_q <= 8'h00;
            clave_q  <= 8'h00;
            lista_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            buffer_q <= buffer_d;
            clave_q  <= clave_d;
            lista_q  <= lista_d;
            error_q  <= error_d;
        end
    end

    assign clave_ingresada = clave_q;
    assign clave_lista     = lista_q;
    assign error_entrada   = error_q;
    assign digitos_cuenta  = estado_q;
endmodule

// File: tb/tb_captura_clave.sv
// tb_captura_clave: table vectors, hand-written timeout/reset sequences and random keys checked against an entry model.
module tb_captura_clave;
    localparam int T = 16;
`ifdef CAPTURA_CLAVE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset, tecla_valida;
    logic [3:0] tecla_codigo;
    logic [7:0] clave_ingresada;
    logic       clave_lista, error_entrada;
    logic [1:0] digitos_cuenta;

    captura_clave #(.TIMEOUT_CICLOS(T)) dut (
        .clock(clock), .reset(reset), .tecla_valida(tecla_valida), .tecla_codigo(tecla_codigo),
        .clave_ingresada(clave_ingresada), .clave_lista(clave_lista),
        .digitos_cuenta(digitos_cuenta), .error_entrada(error_entrada)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [3:0] c;
        logic [7:0] clave;
        logic       lista;
        logic [1:0] cnt;
        logic       err;
    } vec_t;
    vec_t vecs[$];

    int checks = 0, errors = 0;
    int m_n, m_idle;
    logic [3:0] m_hi, m_lo;
    logic [7:0] m_clave;
    logic m_lista, m_err;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Entry model: digits collected so far, the two captured digits and cycles since the last activity.
    task automatic model_step(input logic rst, input logic v, input logic [3:0] c);
        bit key, expire;
        if (rst) begin
            m_n = 0; m_idle = 0; m_clave = 8'h00; m_lista = 0; m_err = 0;
            return;
        end
        key    = v && c <= 4'hB;
        expire = TO_EN && m_n != 0 && m_idle == T - 1 && !key;
        m_lista = 0;
        m_err   = 0;
        if (key) begin
            m_idle = 0;
            if (c <= 4'd9) begin
                if (m_n == 0) begin m_hi = c; m_n = 1; end
                else if (m_n == 1) begin m_lo = c; m_n = 2; end
            end else if (c == 4'hA) begin
                m_n = 0;
            end else begin
                if (m_n == 2) begin m_clave = {m_hi, m_lo}; m_lista = 1; end
                else m_err = 1;
                m_n = 0;
            end
        end else if (expire) begin
            m_err = 1; m_n = 0; m_idle = 0;
        end else begin
            m_idle = m_n == 0 ? 0 : m_idle + 1;
        end
    endtask

    task automatic cycle(input logic rst, input logic v, input logic [3:0] c);
        reset = rst; tecla_valida = v; tecla_codigo = c;
        @(posedge clock);
        model_step(rst, v, c);
        #1;
        check("model_clave", clave_ingresada, m_clave);
        check("model_lista", {7'b0, clave_lista}, {7'b0, m_lista});
        check("model_cuenta", {6'b0, digitos_cuenta}, m_n[7:0]);
        check("model_error", {7'b0, error_entrada}, {7'b0, m_err});
    endtask

    task automatic add(input logic v, input logic [3:0] c, input logic [7:0] clave,
                       input logic lista, input logic [1:0] cnt, input logic err);
        vec_t e;
        e.v = v; e.c = c; e.clave = clave; e.lista = lista; e.cnt = cnt; e.err = err;
        vecs.push_back(e);
    endtask

    task automatic expect_out(input string name, input logic [7:0] clave, input logic lista,
                              input logic [1:0] cnt, input logic err);
        check({name, "_clave"}, clave_ingresada, clave);
        check({name, "_lista"}, {7'b0, clave_lista}, {7'b0, lista});
        check({name, "_cuenta"}, {6'b0, digitos_cuenta}, {6'b0, cnt});
        check({name, "_error"}, {7'b0, error_entrada}, {7'b0, err});
    endtask

    initial begin
        reset = 1; tecla_valida = 0; tecla_codigo = 0;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        expect_out("reset", 8'h00, 0, 2'd0, 0);

        // 4,7,B with gaps; 3,B early enter; 1,A,2,5,9,B; 5,E,F,5,B
        add(1, 4'h4, 8'h00, 0, 1, 0); add(0, 4'h0, 8'h00, 0, 1, 0);
        add(1, 4'h7, 8'h00, 0, 2, 0); add(0, 4'h0, 8'h00, 0, 2, 0);
        add(1, 4'hB, 8'h47, 1, 0, 0); add(0, 4'h0, 8'h47, 0, 0, 0);
        add(1, 4'h3, 8'h47, 0, 1, 0); add(1, 4'hB, 8'h47, 0, 0, 1);
        add(0, 4'h0, 8'h47, 0, 0, 0);
        add(1, 4'h1, 8'h47, 0, 1, 0); add(1, 4'hA, 8'h47, 0, 0, 0);
        add(1, 4'h2, 8'h47, 0, 1, 0); add(1, 4'h5, 8'h47, 0, 2, 0);
        add(1, 4'h9, 8'h47, 0, 2, 0); add(1, 4'hB, 8'h25, 1, 0, 0);
        add(1, 4'hB, 8'h25, 0, 0, 1);
        add(1, 4'h5, 8'h25, 0, 1, 0); add(1, 4'hE, 8'h25, 0, 1, 0);
        add(1, 4'hF, 8'h25, 0, 1, 0); add(1, 4'h5, 8'h25, 0, 2, 0);
        add(1, 4'hB, 8'h55, 1, 0, 0); add(0, 4'h0, 8'h55, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(0, vecs[i].v, vecs[i].c);
            expect_out($sformatf("vec%0d", i), vecs[i].clave, vecs[i].lista, vecs[i].cnt, vecs[i].err);
        end

        cycle(0, 1, 4'h9); cycle(0, 1, 4'h9);
        expect_out("pre_reset", 8'h55, 0, 2'd2, 0);
        cycle(1, 0, 0);
        expect_out("mid_reset", 8'h00, 0, 2'd0, 0);
        cycle(0, 1, 4'hB);
        expect_out("post_reset_enter", 8'h00, 0, 2'd0, 1);

`ifdef CAPTURA_CLAVE_TIMEOUT_EN
        cycle(0, 1, 4'h6);
        for (int i = 0; i < T - 1; i++) begin
            cycle(0, 0, 0);
            expect_out("to_wait", 8'h00, 0, 2'd1, 0);
        end
        cycle(0, 0, 0);
        expect_out("to_expire", 8'h00, 0, 2'd0, 1);
        cycle(0, 0, 0);
        expect_out("to_after", 8'h00, 0, 2'd0, 0);
        cycle(0, 1, 4'h6);
        for (int i = 0; i < T - 1; i++) cycle(0, 0, 0);
        cycle(0, 1, 4'h8);
        expect_out("to_key_wins", 8'h00, 0, 2'd2, 0);
        for (int i = 0; i < T - 1; i++) cycle(0, 0, 0);
        expect_out("to_enter_wait", 8'h00, 0, 2'd2, 0);
        cycle(0, 0, 0);
        expect_out("to_enter_expire", 8'h00, 0, 2'd0, 1);
        cycle(0, 1, 4'h1); cycle(0, 1, 4'h2);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0);
        cycle(0, 1, 4'h3);
        for (int i = 0; i < T - 1; i++) cycle(0, 0, 0);
        expect_out("to_restart", 8'h00, 0, 2'd2, 0);
        cycle(0, 1, 4'hB);
        expect_out("to_enter_at_expiry", 8'h12, 1, 2'd0, 0);
`else
        cycle(0, 1, 4'h6);
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 0);
            expect_out("hold_wait", 8'h00, 0, 2'd1, 0);
        end
        cycle(0, 1, 4'h7); cycle(0, 1, 4'hB);
        expect_out("hold_deliver", 8'h67, 1, 2'd0, 0);
`endif

        for (int b = 0; b < 8; b++) begin
            int p_idle;
            p_idle = (b % 2 == 1) ? 97 : 40;
            for (int i = 0; i < 100; i++) begin
                logic v, r;
                logic [3:0] c;
                v = $urandom_range(0, 99) >= p_idle;
                c = $urandom_range(0, 9) < 6 ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
                r = $urandom_range(0, 299) == 0;
                cycle(r, v, c);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
